// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte image and writes
// it as little-endian 32-bit words into instruction memory, holding the core in reset until verified.
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t      state;
  state_t      state_nxt;
  logic        started;
  logic [7:0]  csum;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [16:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  logic        accept;
  logic [15:0] len_rx;
  logic        last_byte;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_rx    = {rx_data, len_lo};
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = ((word_cnt + 17'd1) == {1'b0, len});

  // Status outputs decode the state register directly, so they move on the transition edge.
  assign rx_ready   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign done       = (state == RUN);
  assign error      = (state == ERR);
  assign core_reset = (state != RUN);

  // started delays the first IDLE exit by one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (started) state_nxt = LEN_LO;
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_rx} > CAPACITY) state_nxt = ERR;
          else if (len_rx == 16'd0)      state_nxt = CHECK;
          else                           state_nxt = DATA;
        end
      end
      DATA:   if (accept && last_byte && last_word) state_nxt = CHECK;
      CHECK:  if (accept) state_nxt = (rx_data == csum) ? RUN : ERR;
      RUN:    if (reload) state_nxt = IDLE;
      ERR:    if (reload) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum      <= 8'd0;
      len_lo    <= 8'd0;
      len       <= 16'd0;
      word_cnt  <= 17'd0;
      byte_cnt  <= 2'd0;
      partial   <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          csum     <= 8'd0;
          word_cnt <= 17'd0;
          byte_cnt <= 2'd0;
        end
        LEN_LO: begin
          if (accept) begin
            csum   <= csum ^ rx_data;
            len_lo <= rx_data;
          end
        end
        LEN_HI: begin
          if (accept) begin
            csum <= csum ^ rx_data;
            len  <= len_rx;
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              mem_wdata <= {rx_data, partial};
              word_cnt  <= word_cnt + 17'd1;
            end else begin
              // Shift in from the top so the first byte ends up in bits [7:0].
              partial <= {rx_data, partial[23:8]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader for the RV32I core's instruction memory. It receives a length-prefixed, checksummed image over a valid/ready byte interface and assembles little-endian 32-bit words. Each word is written into the instruction memory through a single-cycle write port. The core is held in reset until the image has loaded and verified, then released. The core reads the instruction memory; this block is its writer.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs clear immediately on assertion.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle pulse; restarts loading from RUN or ERR.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  word data.
- core_reset  out  1  active-high reset to the core; 1 except in RUN.
- done  out  1  image loaded and verified.
- error  out  1  length overflow or checksum mismatch.

## Operation
- Image format: LEN_LO, LEN_HI (N, 16-bit, little-endian), then 4N data bytes, then one CHK byte.
- A data word is {b3,b2,b1,b0}, where b0 is the first byte received.
- CHK must equal the XOR of every preceding image byte, including both length bytes.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- The state machine is IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERR.
- IDLE → LEN_LO unconditionally on the next edge. Clear the running XOR, word counter and byte counter here.
- LEN_LO → LEN_HI when a byte is accepted.
- LEN_HI, on accepting a byte:
  - N > 2^ADDR_WIDTH → ERR.
  - N == 0 → CHECK.
  - otherwise → DATA.
- DATA: a 2-bit byte counter selects the lane. Whenever a 4th byte is accepted, issue a memory write. When the 4N-th byte is accepted → CHECK.
- CHECK, on accepting a byte: go to RUN if it equals the running XOR, otherwise go to ERR.
- RUN: core_reset=0, done=1. reload → IDLE.
- ERR: error=1, core_reset=1. reload → IDLE.
- reload is ignored in every state except RUN and ERR.
- rx_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK. No backpressure is needed for the memory write.
- Word addresses run 0 .. N-1 in order and never wrap. The N ≤ 2^ADDR_WIDTH check guarantees this.
- Reset mid-load: outputs return to their reset values asynchronously. Words already written stay in memory; there is no rollback. Loading restarts from IDLE.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0. The state is IDLE.
- After reset is released, rx_ready rises on the second rising edge (IDLE → LEN_LO).
- mem_we, mem_addr and mem_wdata are registered:
  - They are valid in the cycle after the edge that accepted a word's 4th byte.
  - mem_we is high for exactly one cycle.
  - mem_addr and mem_wdata hold their values afterwards.
- The last word's write coincides with the first CHECK cycle.
- The edge that accepts CHK moves the state to RUN or ERR. done/error and core_reset change on that same edge, since they are registered state outputs.
- After reload in RUN: core_reset=1 and done=0 on the next edge.
- After reload in ERR: error=0 on the next edge.
- In both cases rx_ready returns one edge later.
- Minimum load time for N words: 4N+3 accepted bytes, plus 2 cycles after reset.

## Test plan
- Single word, contiguous: bytes 01 00 13 00 10 00 02 → one write, addr 0, data 0x00100013. done=1 and core_reset=0 on the edge accepting 0x02. No further writes.
- Two words with rx_valid gaps of 0–3 idle cycles between bytes: bytes 02 00 93 00 10 00 13 81 20 00 33 → writes addr0=0x00100093 and addr1=0x00208113, each with a one-cycle mem_we. done=1.
- Bad checksum: same two-word image with CHK=0x34 → both writes occur, then error=1, done=0, core_reset=1, rx_ready=0. A reload pulse then gives error=0, then rx_ready=1, and a correct reload reaches done.
- Empty image: bytes 00 00 00 → no mem_we, done=1, core_reset=0.
- Overflow with ADDR_WIDTH=8: bytes 01 01 (N=257) → ERR on the edge accepting LEN_HI, no writes, rx_ready=0.
- Async reset asserted between the 2nd and 3rd byte of word 1 → all outputs return to reset values without a clock edge. A full reload of the single-word image then produces done=1 and addr0=0x00100013.
